ysyx_22050612_lsu: RTL and testbench
====================================

Name: ysyx_22050612_lsu

Overview:
Load/store unit directly downstream of the EX-stage ALU. Takes the ALU result as the effective address (or as pass-through data for non-memory ops) and runs one memory transaction on a 64-bit aligned bus. It extracts and extends load data, or builds the store data and byte mask, and hands the result to writeback over a valid/ready handshake. One instruction is in flight at a time.

Parameters:
XLEN, 64, datapath and address width (only 64 supported)
RD_W, 5, destination register index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  EX result valid
in_ready  out  1  LSU can accept (state==IDLE)
in_alu  in  64  ALU Z: effective address, or bypass data
in_sdata  in  64  store source (rs2)
in_op  in  5  {mem_en, is_store, unsigned, size[1:0]}; size 0=B,1=H,2=W,3=D
in_rd  in  RD_W  destination register
mem_req_valid  out  1  bus request valid
mem_req_ready  in  1  bus accepts request
mem_addr  out  64  {addr[63:3],3'b0}
mem_wen  out  1  1=store
mem_wdata  out  64  lane-shifted store data
mem_wmask  out  8  byte enables
mem_rsp_valid  in  1  read data / write ack, one pulse per request
mem_rdata  in  64  read data
out_valid  out  1  result valid to WB
out_ready  in  1  WB accepts
out_data  out  64  load value or bypass value
out_rd  out  RD_W  destination register
out_wen  out  1  register write enable (0 for stores)
out_err  out  1  misaligned access flag (see Optional Feature)

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Reset to IDLE. All outputs except in_ready reset to 0; in_ready=1 in IDLE.
- IDLE: a handshake (in_valid & in_ready) latches in_alu, in_sdata, in_op, in_rd.
  - mem_en=0: next state DONE, out_data=in_alu, out_wen=1.
  - mem_en=1: next state REQ.
- REQ: mem_req_valid=1; addr/wen/wdata/wmask stay stable until mem_req_ready. Same-cycle mem_req_ready moves to WAIT; stall otherwise.
- WAIT: on mem_rsp_valid, move to DONE.
  - Load: lane=addr[2:0]; field = mem_rdata >> (8*lane), truncated to 8/16/32/64 bits. Sign-extend if unsigned=0, zero-extend if unsigned=1. out_wen=1.
  - Store: out_data=0, out_wen=0.
- Store encoding: mem_wdata = in_sdata << (8*lane); mem_wmask = ({1,3,15,255}[size]) << lane, truncated to 8 bits.
- DONE: out_valid=1 and out_* held stable until out_ready, then IDLE. No new acceptance before IDLE (minimum 2 cycles per bypass op, 4 per memory op with zero-wait bus).
- mem_rsp_valid outside WAIT is ignored.
- mem_rsp_valid in the same cycle as mem_req_ready is not accepted; the response must come in a later cycle.
- rst at any state: synchronous return to IDLE and zero outputs. A bus response arriving after reset is discarded.

Optional Feature:
Macro YSYX_22050612_LSU_MISALIGN_CHECK_EN.
- Defined: a memory op with addr not aligned to its size (H: addr[0]≠0; W: addr[1:0]≠0; D: addr[2:0]≠0) skips REQ/WAIT and goes IDLE→DONE. No bus request is issued; out_err=1, out_wen=0, out_data=in_alu (faulting address).
- Undefined: out_err is tied 0. The lane offset is forced aligned down to the access size (low bits masked) and the access proceeds normally.

Test Plan:
- Bypass: in_op=0, in_alu=0x1234 → out_valid two cycles after handshake, out_data=0x1234, out_wen=1, no mem_req_valid.
- Signed byte load: addr=0x80000005, op LB, mem_rdata=0x0000_80FF_0000_0000 (byte5=0x80) → mem_addr=0x80000000, out_data=0xFFFF_FFFF_FFFF_FF80. Same with LBU → 0x80.
- Store half: addr=0x80000006, op SH, sdata=0xABCD → mem_wdata=0xABCD_0000_0000_0000, mem_wmask=0xC0, out_wen=0 after ack.
- Backpressure: mem_req_ready held 0 for 3 cycles, then out_ready held 0 for 2 cycles → request and output fields stable throughout, in_ready=0 until completion.
- Reset mid-WAIT: assert rst in WAIT, then pulse mem_rsp_valid → state IDLE, out_valid never rises, in_ready=1.
- Misalign (macro on): LW at 0x80000002 → no mem_req_valid, out_err=1, out_data=0x80000002; macro off → mem_wmask/lanes as for 0x80000000.

Source files
------------

// File: rtl/ysyx_22050612_lsu.sv
// Single-issue load/store unit behind the EX-stage ALU: one bus transaction per op, result to WB via valid/ready.
// Define YSYX_22050612_LSU_MISALIGN_CHECK_EN to fault misaligned accesses instead of aligning them down.
module ysyx_22050612_lsu #(
    parameter int XLEN = 64,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_alu,
    input  logic [XLEN-1:0] in_sdata,
    input  logic [4:0]      in_op,
    input  logic [RD_W-1:0] in_rd,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_wdata,
    output logic [7:0]      mem_wmask,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [RD_W-1:0] out_rd,
    output logic            out_wen,
    output logic            out_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] alu_q, alu_d;
    logic [XLEN-1:0] sdata_q, sdata_d;
    logic [4:0]      op_q, op_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            wen_q, wen_d;
`ifdef YSYX_22050612_LSU_MISALIGN_CHECK_EN
    logic            err_q, err_d;
`endif
    logic [2:0]      lane;

    // Lane offset rounded down to the access size so the field never straddles the word.
    function automatic logic [2:0] align_lane(input logic [1:0] size, input logic [2:0] a);
        logic [2:0] l;
        case (size)
            2'd0:    l = a;
            2'd1:    l = {a[2:1], 1'b0};
            2'd2:    l = {a[2], 2'b00};
            default: l = 3'd0;
        endcase
        return l;
    endfunction

    function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] rdata, input logic [2:0] ln,
                                                 input logic [1:0] size, input logic uns);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] r;
        sh = rdata >> {ln, 3'b000};
        case (size)
            2'd0:    r = {{(XLEN-8){~uns & sh[7]}}, sh[7:0]};
            2'd1:    r = {{(XLEN-16){~uns & sh[15]}}, sh[15:0]};
            2'd2:    r = {{(XLEN-32){~uns & sh[31]}}, sh[31:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

`ifdef YSYX_22050612_LSU_MISALIGN_CHECK_EN
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] a);
        logic m;
        case (size)
            2'd0:    m = 1'b0;
            2'd1:    m = a[0];
            2'd2:    m = |a[1:0];
            default: m = |a;
        endcase
        return m;
    endfunction
`endif

    assign lane = align_lane(op_q[1:0], alu_q[2:0]);

    always_comb begin
        state_d = state_q;
        alu_d   = alu_q;
        sdata_d = sdata_q;
        op_d    = op_q;
        rd_d    = rd_q;
        data_d  = data_q;
        wen_d   = wen_q;
`ifdef YSYX_22050612_LSU_MISALIGN_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    alu_d   = in_alu;
                    sdata_d = in_sdata;
                    op_d    = in_op;
                    rd_d    = in_rd;
`ifdef YSYX_22050612_LSU_MISALIGN_CHECK_EN
                    err_d   = 1'b0;
`endif
                    if (!in_op[4]) begin
                        data_d  = in_alu;
                        wen_d   = 1'b1;
                        state_d = DONE;
                    end
`ifdef YSYX_22050612_LSU_MISALIGN_CHECK_EN
                    else if (misaligned(in_op[1:0], in_alu[2:0])) begin
                        data_d  = in_alu;
                        wen_d   = 1'b0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
`endif
                    else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    state_d = DONE;
                    if (op_q[3]) begin
                        data_d = '0;
                        wen_d  = 1'b0;
                    end else begin
                        data_d = load_ext(mem_rdata, lane, op_q[1:0], op_q[2]);
                        wen_d  = 1'b1;
                    end
                end
            end
            default: begin
                if (out_ready) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Payload registers are only observed through state-gated outputs, so they need no reset.
    always_ff @(posedge clk) begin
        alu_q   <= alu_d;
        sdata_q <= sdata_d;
        op_q    <= op_d;
        rd_q    <= rd_d;
        data_q  <= data_d;
        wen_q   <= wen_d;
`ifdef YSYX_22050612_LSU_MISALIGN_CHECK_EN
        err_q   <= err_d;
`endif
    end

    assign in_ready      = (state_q == IDLE);
    assign mem_req_valid = (state_q == REQ);
    assign mem_addr      = mem_req_valid ? {alu_q[XLEN-1:3], 3'b000} : '0;
    assign mem_wen       = mem_req_valid & op_q[3];
    assign mem_wdata     = (mem_req_valid & op_q[3]) ? (sdata_q << {lane, 3'b000}) : '0;
    assign mem_wmask     = mem_req_valid ? ((op_q[1:0] == 2'd0) ? (8'h01 << lane) :
                                            (op_q[1:0] == 2'd1) ? (8'h03 << lane) :
                                            (op_q[1:0] == 2'd2) ? (8'h0F << lane) : 8'hFF) : 8'h00;

    assign out_valid = (state_q == DONE);
    assign out_data  = out_valid ? data_q : '0;
    assign out_rd    = out_valid ? rd_q : '0;
    assign out_wen   = out_valid & wen_q;
`ifdef YSYX_22050612_LSU_MISALIGN_CHECK_EN
    assign out_err   = out_valid & err_q;
`else
    assign out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22050612_lsu.sv
// Directed vector bench for ysyx_22050612_lsu: table of single ops plus backpressure and reset sequences.
module tb_ysyx_22050612_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_alu;
    logic [63:0] in_sdata;
    logic [4:0]  in_op;
    logic [4:0]  in_rd;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic [63:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        out_err;

    int checks = 0;
    int errors = 0;

    ysyx_22050612_lsu #(.XLEN(64), .RD_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_alu(in_alu), .in_sdata(in_sdata),
        .in_op(in_op), .in_rd(in_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
        .out_wen(out_wen), .out_err(out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [63:0] alu;
        logic [63:0] sdata;
        logic [63:0] rdata;
        logic        e_req;
        logic [63:0] e_addr;
        logic [63:0] e_wdata;
        logic [7:0]  e_wmask;
        logic [63:0] e_data;
        logic        e_wen;
        logic        e_err;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [4:0] op, input logic [63:0] alu, input logic [63:0] sdata,
                                input logic [63:0] rdata, input logic e_req, input logic [63:0] e_addr,
                                input logic [63:0] e_wdata, input logic [7:0] e_wmask,
                                input logic [63:0] e_data, input logic e_wen, input logic e_err);
        vec_t v;
        v.op = op; v.alu = alu; v.sdata = sdata; v.rdata = rdata; v.e_req = e_req;
        v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_wmask = e_wmask;
        v.e_data = e_data; v.e_wen = e_wen; v.e_err = e_err;
        return v;
    endfunction

    task automatic handshake(input logic [4:0] op, input logic [63:0] alu, input logic [63:0] sdata,
                             input logic [4:0] rd);
        chk("in_ready_before_hs", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1; in_op = op; in_alu = alu; in_sdata = sdata; in_rd = rd;
        tick();
        in_valid = 1'b0; in_alu = '1; in_sdata = '1; in_op = 5'h1F; in_rd = 5'h1F;
    endtask

    task automatic run_vec(input vec_t v, input logic [4:0] rd);
        handshake(v.op, v.alu, v.sdata, rd);
        chk("req_valid", {63'd0, mem_req_valid}, {63'd0, v.e_req});
        if (v.e_req) begin
            chk("mem_addr", mem_addr, v.e_addr);
            chk("mem_wen", {63'd0, mem_wen}, {63'd0, v.op[3]});
            chk("mem_wdata", mem_wdata, v.e_wdata);
            chk("mem_wmask", {56'd0, mem_wmask}, {56'd0, v.e_wmask});
            mem_req_ready = 1'b1;
            tick();
            mem_req_ready = 1'b0;
            chk("req_dropped", {63'd0, mem_req_valid}, 64'd0);
            mem_rsp_valid = 1'b1; mem_rdata = v.rdata;
            tick();
            mem_rsp_valid = 1'b0; mem_rdata = '0;
        end
        chk("out_valid", {63'd0, out_valid}, 64'd1);
        chk("out_data", out_data, v.e_data);
        chk("out_wen", {63'd0, out_wen}, {63'd0, v.e_wen});
        chk("out_err", {63'd0, out_err}, {63'd0, v.e_err});
        chk("out_rd", {59'd0, out_rd}, {59'd0, rd});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_drop", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_alu = '0; in_sdata = '0; in_op = '0; in_rd = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0; out_ready = 1'b0;

        vecs[0]  = mk(5'b00000, 64'h1234, 64'h0, 64'h0, 1'b0, 64'h0, 64'h0, 8'h00, 64'h1234, 1'b1, 1'b0);
        vecs[1]  = mk(5'b10000, 64'h8000_0005, 64'h0, 64'h0000_80FF_0000_0000, 1'b1, 64'h8000_0000,
                      64'h0, 8'h20, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0);
        vecs[2]  = mk(5'b10100, 64'h8000_0005, 64'h0, 64'h0000_80FF_0000_0000, 1'b1, 64'h8000_0000,
                      64'h0, 8'h20, 64'h80, 1'b1, 1'b0);
        vecs[3]  = mk(5'b11001, 64'h8000_0006, 64'hABCD, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 64'h8000_0000,
                      64'hABCD_0000_0000_0000, 8'hC0, 64'h0, 1'b0, 1'b0);
        vecs[4]  = mk(5'b10011, 64'h8000_0008, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b1, 64'h8000_0008,
                      64'h0, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
        vecs[5]  = mk(5'b10010, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 1'b1, 64'h8000_0000,
                      64'h0, 8'hF0, 64'hFFFF_FFFF_8765_4321, 1'b1, 1'b0);
        vecs[6]  = mk(5'b10110, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 1'b1, 64'h8000_0000,
                      64'h0, 8'hF0, 64'h0000_0000_8765_4321, 1'b1, 1'b0);
        vecs[7]  = mk(5'b10001, 64'h8000_0002, 64'h0, 64'h0000_0000_F00D_0000, 1'b1, 64'h8000_0000,
                      64'h0, 8'h0C, 64'hFFFF_FFFF_FFFF_F00D, 1'b1, 1'b0);
        vecs[8]  = mk(5'b11000, 64'h8000_0003, 64'h5A, 64'h0, 1'b1, 64'h8000_0000,
                      64'h0000_0000_5A00_0000, 8'h08, 64'h0, 1'b0, 1'b0);
        vecs[9]  = mk(5'b11011, 64'h8000_0010, 64'h1122_3344_5566_7788, 64'h0, 1'b1, 64'h8000_0010,
                      64'h1122_3344_5566_7788, 8'hFF, 64'h0, 1'b0, 1'b0);
        vecs[10] = mk(5'b01011, 64'hFFFF, 64'h77, 64'h0, 1'b0, 64'h0, 64'h0, 8'h00, 64'hFFFF, 1'b1, 1'b0);
`ifdef YSYX_22050612_LSU_MISALIGN_CHECK_EN
        vecs[11] = mk(5'b10010, 64'h8000_0002, 64'h0, 64'h0, 1'b0, 64'h0, 64'h0, 8'h00,
                      64'h8000_0002, 1'b0, 1'b1);
`else
        vecs[11] = mk(5'b10010, 64'h8000_0002, 64'h0, 64'h0000_0000_CAFE_BABE, 1'b1, 64'h8000_0000,
                      64'h0, 8'h0F, 64'hFFFF_FFFF_CAFE_BABE, 1'b1, 1'b0);
`endif

        tick(); tick();
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_wmask", {56'd0, mem_wmask}, 64'd0);
        chk("rst_out_err", {63'd0, out_err}, 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) run_vec(vecs[i], 5'(i + 1));

        // Backpressure on both sides, plus a response coincident with request acceptance.
        handshake(5'b11010, 64'h8000_0004, 64'h1234_5678, 5'd20);
        for (int c = 0; c < 3; c++) begin
            chk("bp_req_valid", {63'd0, mem_req_valid}, 64'd1);
            chk("bp_addr", mem_addr, 64'h8000_0000);
            chk("bp_wdata", mem_wdata, 64'h1234_5678_0000_0000);
            chk("bp_wmask", {56'd0, mem_wmask}, 64'hF0);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            tick();
        end
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1;
        tick();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        chk("bp_same_cycle_rsp_ignored", {63'd0, out_valid}, 64'd0);
        tick();
        chk("bp_wait_hold", {63'd0, out_valid}, 64'd0);
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_out_wen", {63'd0, out_wen}, 64'd0);
            chk("bp_out_data", out_data, 64'd0);
            chk("bp_out_rd", {59'd0, out_rd}, 64'd20);
            chk("bp_in_ready_done", {63'd0, in_ready}, 64'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_in_ready_after", {63'd0, in_ready}, 64'd1);

        // Reset while waiting for a load response; the late response must be dropped.
        handshake(5'b10011, 64'h8000_0020, 64'h0, 5'd9);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rw_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rw_req_valid", {63'd0, mem_req_valid}, 64'd0);
        mem_rsp_valid = 1'b1; mem_rdata = 64'h5555_AAAA_5555_AAAA;
        tick();
        mem_rsp_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("rw_out_valid", {63'd0, out_valid}, 64'd0);
            chk("rw_in_ready_hold", {63'd0, in_ready}, 64'd1);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
